// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package mips_pkg;

    // Fetch/execute sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

    // J-type jump target fields: word index taken from the instruction,
    // region bits kept from PC+4.
    localparam int JIDX_MSB = 25;
    localparam int JIDX_LSB = 0;
    localparam int JUP_MSB  = 31;
    localparam int JUP_LSB  = 28;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory port of the fetch stage.
// Handshake: the master raises imem_req with imem_addr and holds both
// stable until the slave answers with a one-cycle imem_ack pulse carrying
// imem_rdata, or until the master abandons the request on timeout.
// imem_rdata is meaningful only in a cycle where imem_ack=1.
interface instr_fetch_unit_if;
    import mips_pkg::*;

    logic               imem_req;
    logic [31:0]        imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ack
    );

endinterface

// File: rtl/instr_fetch_unit_next_pc.sv
// Combinational next-PC selection: sequential, branch and jump targets.
module next_pc_logic
    import mips_pkg::*;
(
    input  logic [31:0]                i_pc,
    input  logic [JIDX_MSB-JIDX_LSB:0] i_jidx,
    input  logic [29:0]                i_imm,
    input  logic                       i_pcsrc,
    input  logic                       i_jump,
    output logic [31:0]                o_pc_plus4,
    output logic [31:0]                o_next_pc,
    output logic                       o_misaligned
);

    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_tgt;
    logic [31:0] w_jump_tgt;
    logic [31:0] w_next_pc;

    // Targets are 32-bit modulo; the branch offset drops SignImm[31:30]
    // because the word shift pushes them out anyway.
    always_comb begin
        w_pc_plus4   = i_pc + 32'd4;
        w_branch_tgt = w_pc_plus4 + {i_imm, 2'b00};
        w_jump_tgt   = {w_pc_plus4[JUP_MSB:JUP_LSB], i_jidx, 2'b00};
        // Jump overrides a simultaneous branch decision
        if (i_jump) begin
            w_next_pc = w_jump_tgt;
        end else if (i_pcsrc) begin
            w_next_pc = w_branch_tgt;
        end else begin
            w_next_pc = w_pc_plus4;
        end
    end

    assign o_pc_plus4   = w_pc_plus4;
    assign o_next_pc    = w_next_pc;
    assign o_misaligned = (w_next_pc[1:0] != 2'b00);

endmodule

// File: rtl/instr_fetch_unit.sv
// PC register and instruction fetch sequencer with stall and fetch timeout.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          ACK_TIMEOUT = 16,
    parameter int          CNT_W       = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                PCSrc,
    input  logic                Jump,
    input  logic [31:0]         SignImm,
    instr_fetch_unit_if.master  imem,
    output logic [INSTR_W-1:0]  Instr,
    output logic                instr_valid,
    output logic [31:0]         PC,
    output logic [31:0]         PCPlus4,
    output logic                fetch_err,
    output state_t              o_dbg_state
);

    state_t             r_state;
    logic [31:0]        r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic               r_instr_valid;
    logic               r_imem_req;
    logic               r_fetch_err;
    logic [CNT_W-1:0]   r_cnt;

    logic [31:0]        w_pc_plus4;
    logic [31:0]        w_next_pc;
    logic               w_misaligned;
    logic               w_timeout;

    next_pc_logic u_next_pc (
        .i_pc         (r_pc),
        .i_jidx       (r_instr[JIDX_MSB:JIDX_LSB]),
        .i_imm        (SignImm[29:0]),
        .i_pcsrc      (PCSrc),
        .i_jump       (Jump),
        .o_pc_plus4   (w_pc_plus4),
        .o_next_pc    (w_next_pc),
        .o_misaligned (w_misaligned)
    );

    // The counter holds the number of ack-less FETCH cycles already spent,
    // so this cycle without an ack would be the ACK_TIMEOUT-th one.
    assign w_timeout = (r_cnt == CNT_W'(ACK_TIMEOUT - 1));

    // Fetch/execute FSM with registered outputs; reset overrides everything,
    // including an in-flight request whose ack may still arrive later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_pc          <= RESET_PC;
            r_instr       <= NOP;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b0;
            r_fetch_err   <= 1'b0;
            r_cnt         <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_imem_req <= 1'b1;
                    r_cnt      <= '0;
                    r_state    <= FETCH;
                end
                FETCH: begin
                    // An ack in the timeout cycle still completes the fetch
                    if (imem.imem_ack) begin
                        r_instr       <= imem.imem_rdata;
                        r_cnt         <= '0;
                        r_imem_req    <= 1'b0;
                        r_instr_valid <= 1'b1;
                        r_state       <= EXEC;
                    end else if (w_timeout) begin
                        r_cnt       <= r_cnt + 1'b1;
                        r_fetch_err <= 1'b1;
                        r_imem_req  <= 1'b0;
                        r_state     <= HALT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                EXEC: begin
                    // A stalled instruction keeps PC, Instr and instr_valid
                    if (!stall) begin
                        r_pc          <= w_next_pc;
                        r_instr_valid <= 1'b0;
                        if (w_misaligned) begin
                            r_fetch_err <= 1'b1;
                            r_state     <= HALT;
                        end else begin
                            r_imem_req <= 1'b1;
                            r_state    <= FETCH;
                        end
                    end
                end
                HALT: begin
                    r_state <= HALT;
                end
                default: begin
                    r_state <= HALT;
                end
            endcase
        end
    end

    assign imem.imem_req  = r_imem_req;
    assign imem.imem_addr = r_pc;
    assign Instr          = r_instr;
    assign instr_valid    = r_instr_valid;
    assign PC             = r_pc;
    assign PCPlus4        = w_pc_plus4;
    assign fetch_err      = r_fetch_err;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus random
// fetch/stall/branch traffic against a PC reference model.
module tb_instr_fetch_unit;
    import mips_pkg::*;

    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam int          ACK_TIMEOUT = 16;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        PCSrc = 1'b0;
    logic        Jump = 1'b0;
    logic [31:0] SignImm = 32'h0;
    logic [31:0] Instr;
    logic        instr_valid;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        fetch_err;
    state_t      dbg_state;

    always #5 clk = ~clk;

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(
        .RESET_PC    (RESET_PC),
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .CNT_W       (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .PCSrc       (PCSrc),
        .Jump        (Jump),
        .SignImm     (SignImm),
        .imem        (bus),
        .Instr       (Instr),
        .instr_valid (instr_valid),
        .PC          (PC),
        .PCPlus4     (PCPlus4),
        .fetch_err   (fetch_err),
        .o_dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] addr_q[$];    // expected fetch addresses
    logic [63:0] exp_q[$];     // expected {PC, Instr} at each EXEC entry
    int          lat_q[$];     // expected cycles from request to instr_valid
    logic [31:0] model_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_req(output bit ok);
        int n;
        n = 0;
        while (bus.imem_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = (bus.imem_req === 1'b1);
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_req: imem_req got 0 required 1 within 50 cycles");
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.imem_ack = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        check("rst_pc", PC, RESET_PC);
        check("rst_instr", Instr, 32'h0);
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_req", 32'(bus.imem_req), 32'h0);
        check("rst_err", 32'(fetch_err), 32'h0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        model_pc = RESET_PC;
        addr_q.push_back(RESET_PC);
    endtask

    // One instruction: ack after w wait cycles, s stall cycles in EXEC,
    // then release with the given control decision.
    task automatic do_instr(input int w, input int s, input logic [31:0] rdata,
                            input logic pcsrc, input logic jump, input logic [31:0] simm);
        bit          ok;
        logic [31:0] pc4;
        wait_req(ok);
        if (!ok) return;
        repeat (w) @(negedge clk);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = rdata;
        exp_q.push_back({model_pc, rdata});
        lat_q.push_back(w + 1);
        @(negedge clk);
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom;
        for (int i = 0; i < s; i++) begin
            stall   = 1'b1;
            PCSrc   = 1'($urandom);
            Jump    = 1'($urandom);
            SignImm = $urandom;
            @(negedge clk);
        end
        stall   = 1'b0;
        PCSrc   = pcsrc;
        Jump    = jump;
        SignImm = simm;
        pc4 = model_pc + 32'd4;
        if (jump)       model_pc = {pc4[31:28], rdata[25:0], 2'b00};
        else if (pcsrc) model_pc = pc4 + (simm << 2);
        else            model_pc = pc4;
        addr_q.push_back(model_pc);
        @(negedge clk);
        PCSrc   = 1'($urandom);
        Jump    = 1'($urandom);
        SignImm = $urandom;
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        logic        prev_req;
        logic        prev_valid;
        logic [31:0] a;
        logic [63:0] e;
        logic [31:0] cur_pc;
        logic [31:0] cur_instr;
        int          cyc;
        int          req_cyc;
        int          lat;
        prev_req = 1'b0;
        prev_valid = 1'b0;
        cur_pc = '0;
        cur_instr = '0;
        cyc = 0;
        req_cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (bus.imem_req && !prev_req) begin
                    req_cyc = cyc;
                    if (addr_q.size() == 0) begin
                        check("addr_q_underflow", 32'd1, 32'd0);
                    end else begin
                        a = addr_q.pop_front();
                        check("fetch_addr", bus.imem_addr, a);
                        check("pc_in_fetch", PC, a);
                    end
                end
                if (instr_valid && !prev_valid) begin
                    if (exp_q.size() == 0 || lat_q.size() == 0) begin
                        check("exp_q_underflow", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        lat = lat_q.pop_front();
                        cur_pc = e[63:32];
                        cur_instr = e[31:0];
                        check("exec_pc", PC, cur_pc);
                        check("exec_instr", Instr, cur_instr);
                        check("exec_pcplus4", PCPlus4, cur_pc + 32'd4);
                        check("exec_err", 32'(fetch_err), 32'h0);
                        check("latency", 32'(cyc - req_cyc), 32'(lat));
                    end
                end else if (instr_valid) begin
                    check("stall_pc", PC, cur_pc);
                    check("stall_instr", Instr, cur_instr);
                    check("stall_req", 32'(bus.imem_req), 32'h0);
                end
            end
            prev_req = bus.imem_req;
            prev_valid = instr_valid;
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        bit          ok;
        int          n;
        logic [31:0] simm;
        logic [31:0] pc_hold;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'h0;
        model_pc = RESET_PC;
        apply_reset();

        // sequential fetch with one wait cycle
        do_instr(1, 0, $urandom, 1'b0, 1'b0, $urandom);
        do_instr(1, 0, $urandom, 1'b0, 1'b0, $urandom);
        do_instr(1, 0, $urandom, 1'b0, 1'b0, $urandom);
        do_instr(1, 0, $urandom, 1'b0, 1'b0, $urandom);       // 0x0C -> 0x10
        // branches back and forward from 0x10
        do_instr(0, 0, $urandom, 1'b1, 1'b0, 32'hFFFF_FFFE);  // 0x10 -> 0x0C
        do_instr(0, 0, $urandom, 1'b0, 1'b0, 32'h0);          // 0x0C -> 0x10
        do_instr(0, 0, $urandom, 1'b1, 1'b0, 32'h0000_0003);  // 0x10 -> 0x20
        do_instr(2, 0, $urandom, 1'b1, 1'b0, 32'h0FFF_FFFB);  // 0x20 -> 0x4000_0010
        // jump beats branch
        do_instr(0, 0, 32'h0800_0100, 1'b1, 1'b1, 32'h0000_0040);  // -> 0x4000_0400
        // four stall cycles, then a single +4
        do_instr(1, 4, $urandom, 1'b0, 1'b0, $urandom);
        // branch to the top word, then wrap to zero
        do_instr(0, 1, $urandom, 1'b1, 1'b0, 32'h2FFF_FEFD);  // -> 0xFFFF_FFFC
        do_instr(0, 0, $urandom, 1'b0, 1'b0, $urandom);       // -> 0x0
        do_instr(1, 0, $urandom, 1'b0, 1'b0, $urandom);

        // random traffic
        for (int i = 0; i < 40; i++) begin
            simm = $urandom_range(0, 64);
            simm = simm - 32'd32;
            do_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                     ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 2), simm);
        end

        // timeout: never acknowledge
        wait_req(ok);
        pc_hold = model_pc;
        n = 0;
        while (bus.imem_req === 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", 32'(n), 32'(ACK_TIMEOUT));
        check("timeout_err", 32'(fetch_err), 32'h1);
        for (int i = 0; i < 5; i++) begin
            check("halt_state", 32'(dbg_state), 32'(HALT));
            check("halt_req", 32'(bus.imem_req), 32'h0);
            check("halt_pc", PC, pc_hold);
            check("halt_valid", 32'(instr_valid), 32'h0);
            @(negedge clk);
        end
        apply_reset();

        // reset in the middle of a fetch, then a late ack
        wait_req(ok);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_req", 32'(bus.imem_req), 32'h0);
        check("midrst_pc", PC, RESET_PC);
        rst = 1'b0;
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        model_pc = RESET_PC;
        addr_q.push_back(RESET_PC);
        @(negedge clk);
        bus.imem_ack = 1'b0;
        check("late_ack_instr", Instr, 32'h0);
        check("late_ack_valid", 32'(instr_valid), 32'h0);
        check("late_ack_err", 32'(fetch_err), 32'h0);
        do_instr(0, 0, $urandom, 1'b0, 1'b0, $urandom);
        do_instr(1, 2, $urandom, 1'b1, 1'b0, 32'h0000_0010);

        repeat (3) @(negedge clk);
        check("addr_q_drained", 32'(addr_q.size()), 32'h0);
        check("exp_q_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Program-counter and instruction-fetch stage directly upstream of the control unit.
- Holds the PC and fetches the 32-bit instruction from instruction memory over a req/ack handshake.
- Presents the instruction as Instr for one execute cycle, then computes the next PC from the control unit's PCSrc/Jump decisions.
- Adds stall support and a fetch timeout so slow or absent memory cannot hang the core silently.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- ACK_TIMEOUT, 16, maximum cycles FETCH waits for imem_ack before flagging an error.
- CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > ACK_TIMEOUT.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  holds the EXEC state; PC and Instr are frozen.
- PCSrc  in  1  Branch & zero from the control unit; selects the branch target.
- Jump  in  1  from the control unit; selects the jump target and overrides PCSrc.
- SignImm  in  32  sign-extended immediate from the datapath.
- imem_rdata  in  32  instruction memory read data; valid when imem_ack=1.
- imem_ack  in  1  instruction memory acknowledge, one-cycle pulse.
- imem_req  out  1  fetch request; held high until ack or timeout.
- imem_addr  out  32  fetch address; always equals PC.
- Instr  out  32  registered instruction to the control unit and datapath.
- instr_valid  out  1  high only in EXEC; qualifies Instr for register-file and memory writes.
- PC  out  32  current program counter.
- PCPlus4  out  32  PC + 4, for JAL-style uses and branch arithmetic.
- fetch_err  out  1  sticky; set on timeout or misaligned target, cleared only by rst.

Behaviour:
- Reset values (rst=1 at an edge): PC=RESET_PC, Instr=0, instr_valid=0, imem_req=0, fetch_err=0, timeout counter=0, state=IDLE.
- Reset has priority over every other input, in any state, including mid-FETCH. A late ack arriving after reset is ignored.
- State IDLE:
  - One cycle after reset, then -> FETCH.
  - imem_req=0.
- State FETCH:
  - imem_req=1 and imem_addr=PC.
  - Counter increments each cycle without ack.
  - On imem_ack=1: Instr <= imem_rdata, counter <= 0, -> EXEC.
  - If the counter reaches ACK_TIMEOUT with no ack: fetch_err <= 1, imem_req <= 0, -> HALT.
  - Ack and timeout in the same cycle: the ack wins.
- State EXEC:
  - instr_valid=1 and imem_req=0.
  - If stall=1: stay in EXEC; PC, Instr and instr_valid are held.
  - If stall=0: PC <= next_pc, then -> FETCH. instr_valid is therefore high for exactly one cycle per unstalled instruction.
- State HALT: terminal; all outputs held; only rst exits.
- next_pc (combinational, sampled only in EXEC):
  - Jump=1: {PCPlus4[31:28], Instr[25:0], 2'b00}.
  - else PCSrc=1: PCPlus4 + {SignImm[29:0], 2'b00}.
  - else: PCPlus4.
  - Jump and PCSrc both high: Jump wins.
- Arithmetic: 32-bit modulo; PC wraps 32'hFFFF_FFFC -> 32'h0000_0000 with no error.
- Misalignment: if next_pc[1:0] != 0 (possible only through a corrupted RESET_PC), set fetch_err and go to HALT instead of FETCH.
- Latency: minimum 2 cycles per instruction (FETCH with same-cycle ack, then EXEC); each ack wait cycle and each stall cycle adds one.
- imem_rdata is ignored whenever imem_ack=0 or state != FETCH.

Decomposition:
- Shared package mips_pkg holds:
  - state enum: IDLE, FETCH, EXEC, HALT.
  - INSTR_W=32.
  - localparam NOP=32'h0.
  - jump-target field positions: index [25:0], upper PC bits [31:28].
- One sub-module, next_pc_logic: purely combinational mux and adders (PCPlus4, branch target, jump target, misalignment flag). The FSM, PC register and timeout counter stay in instr_fetch_unit.

Test Plan:
- Sequential fetch: reset, memory acks every request after 1 wait cycle -> PC steps 0x0, 0x4, 0x8; instr_valid pulses every 3 cycles; imem_addr equals PC during each FETCH.
- Branch taken:
  - PC=0x10, PCSrc=1, SignImm=32'hFFFF_FFFE in EXEC -> next PC=0x0C.
  - Same with SignImm=3 -> 0x20.
- Jump priority: PC=0x4000_0010, Instr=32'h0800_0100, Jump=1, PCSrc=1 -> next PC=0x4000_0400.
- Stall: hold stall=1 for 4 EXEC cycles -> PC, Instr and instr_valid=1 all constant; no imem_req; after release, PC advances by exactly 4 once.
- Timeout: never ack, ACK_TIMEOUT=16 -> fetch_err=1 and imem_req=0 after 16 FETCH cycles; state stuck until rst; rst clears fetch_err and reloads RESET_PC.
- Reset mid-FETCH and wrap:
  - Assert rst while imem_req=1 -> next cycle imem_req=0 and PC=RESET_PC; a late ack is ignored.
  - With RESET_PC=0xFFFF_FFFC, sequential fetch gives next PC=0x0, fetch_err=0.
